// File: rtl/display_pkg.sv
// display_pkg: shared types and constants for the seven-segment scanner.
//   scan_state_e : per-slot phase, BLANK (anti-ghost gap) then DRIVE
//   SEG_OFF      : all segments dark (segments are active-low)
//   HEX_SEG      : hex code -> {g,f,e,d,c,b,a} active-low glyph table
// Optional feature macro used by the scanner: DISPLAY_SCANNER_PWM_EN.
package display_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Index 15 first: F,E,d,C,b,A,9,8,7,6,5,4,3,2,1,0
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] code);
        return HEX_SEG[code];
    endfunction

endpackage

// File: rtl/display_scanner_if.sv
// display_scanner_if: bundles the display data inputs and the pin-side
// outputs of display_scanner.
//   master : the time logic side (drives digits/digit_en/dp_en[/brightness])
//   slave  : the scanner (drives anode_sel/seg/dp/digit_idx/frame_done)
// With DISPLAY_SCANNER_PWM_EN defined a 4-bit brightness signal is added.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0]       digits;
    logic [NUM_DIGITS-1:0]         digit_en;
    logic [NUM_DIGITS-1:0]         dp_en;
`ifdef DISPLAY_SCANNER_PWM_EN
    logic [3:0]                    brightness;
`endif
    logic [NUM_DIGITS-1:0]         anode_sel;
    logic [6:0]                    seg;
    logic                          dp;
    logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
    logic                          frame_done;

    modport master (
`ifdef DISPLAY_SCANNER_PWM_EN
        output brightness,
`endif
        output digits, digit_en, dp_en,
        input  anode_sel, seg, dp, digit_idx, frame_done
    );

    modport slave (
`ifdef DISPLAY_SCANNER_PWM_EN
        input  brightness,
`endif
        input  digits, digit_en, dp_en,
        output anode_sel, seg, dp, digit_idx, frame_done
    );
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex -> seven-segment decoder.
//   code_i : 4-bit hex code
//   seg_o  : {g,f,e,d,c,b,a}, active-low
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex_to_seg(code_i);
endmodule

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexed common-anode seven-segment driver.
// Each of NUM_DIGITS slots lasts CLK_DIV clocks: BLANK_CYCLES with all
// anodes off, then the rest driving the slot's digit. Digit data is
// snapshotted at each frame wrap so a frame never mixes old and new data.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : display_scanner_if.slave (data in, anode/seg/dp/idx/frame out)
// Optional macro DISPLAY_SCANNER_PWM_EN: adds bus.brightness, which trims
// the lit part of each DRIVE window to (drive_len*brightness)>>4 cycles.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 100000,
    parameter int BLANK_CYCLES     = 500,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    display_scanner_if.slave bus
);
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = ANODE_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]                slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d;
    scan_state_e                     state_q, state_d;
    logic                            wrap_q, wrap_d;   // first cycle of slot 0 after a wrap
    logic                            init_q;           // first cycle after reset release
    logic [NUM_DIGITS-1:0][3:0]      snap_dig_q;
    logic [NUM_DIGITS-1:0]           snap_en_q, snap_dp_q;
`ifdef DISPLAY_SCANNER_PWM_EN
    logic [3:0]                      snap_bri_q;
`endif

    logic [NUM_DIGITS-1:0]           anode_q, anode_d;
    logic [6:0]                      seg_q, seg_d;
    logic                            dp_q, dp_d;
    logic [IDX_W-1:0]                digit_idx_q;
    logic                            frame_done_q;

    logic                            slot_end, last_idx, blank_end, snap_load;
    logic                            pwm_ok, lit;
    logic [NUM_DIGITS-1:0]           onehot;
    logic [6:0]                      dec_seg;

    assign slot_end  = (slot_cnt_q == CNT_W'(CLK_DIV - 1));
    assign last_idx  = (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign blank_end = (BLANK_CYCLES == 0) || (slot_cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign snap_load = init_q || (slot_end && last_idx);

    // ---------------- prescaler, index, FSM next state ----------------
    always_comb begin
        slot_cnt_d = slot_end ? '0 : slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        wrap_d     = slot_end && last_idx;
        state_d    = state_q;
        if (slot_end) idx_d = last_idx ? '0 : idx_q + 1'b1;
        case (state_q)
            BLANK:   if (blank_end) state_d = DRIVE;
            // With no blank interval the FSM simply stays in DRIVE.
            DRIVE:   if (slot_end && BLANK_CYCLES != 0) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            state_q    <= BLANK;
            wrap_q     <= 1'b0;
            init_q     <= 1'b1;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
            wrap_q     <= wrap_d;
            init_q     <= 1'b0;
        end
    end

    // ---------------- frame snapshot ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_dig_q <= '0;
            snap_en_q  <= '0;
            snap_dp_q  <= '0;
`ifdef DISPLAY_SCANNER_PWM_EN
            snap_bri_q <= '0;
`endif
        end else if (snap_load) begin
            snap_dig_q <= bus.digits;
            snap_en_q  <= bus.digit_en;
            snap_dp_q  <= bus.dp_en;
`ifdef DISPLAY_SCANNER_PWM_EN
            snap_bri_q <= bus.brightness;
`endif
        end
    end

    // ---------------- output decode ----------------
`ifdef DISPLAY_SCANNER_PWM_EN
    localparam logic [CNT_W:0] DRIVE_LEN = (CNT_W + 1)'(CLK_DIV - BLANK_CYCLES);
    logic [CNT_W+4:0] pwm_prod;
    logic [CNT_W:0]   pwm_off;
    // Offset into the drive window; only meaningful while in DRIVE.
    assign pwm_prod = {4'b0, DRIVE_LEN} * {{(CNT_W + 1){1'b0}}, snap_bri_q};
    assign pwm_off  = {1'b0, slot_cnt_q} - (CNT_W + 1)'(BLANK_CYCLES);
    assign pwm_ok   = (pwm_off < pwm_prod[CNT_W+4:4]);
`else
    assign pwm_ok   = 1'b1;
`endif

    seg7_decode u_dec (
        .code_i (snap_dig_q[idx_q]),
        .seg_o  (dec_seg)
    );

    assign onehot = NUM_DIGITS'(1) << idx_q;
    assign lit    = (state_q == DRIVE) && snap_en_q[idx_q] && pwm_ok;

    always_comb begin
        anode_d = ANODE_OFF;
        seg_d   = SEG_OFF;
        dp_d    = 1'b1;
        if (lit) begin
            anode_d = ANODE_ACTIVE_LOW ? ~onehot : onehot;
            seg_d   = dec_seg;
            dp_d    = ~snap_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            anode_q      <= ANODE_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            digit_idx_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            anode_q      <= anode_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            digit_idx_q  <= idx_q;
            frame_done_q <= wrap_q;
        end
    end

    assign bus.anode_sel  = anode_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.digit_idx  = digit_idx_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (4 digits, 8-cycle slots, 2 blank cycles,
// active-low anodes). Inputs are logged per cycle; expected outputs are
// computed from the cycle number since reset release with plain arithmetic
// (slot, digit and frame positions) and the logged input that the frame
// snapshot should hold.
module tb_display_scanner;
    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * CD;
    localparam int HMAX  = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    display_scanner_if #(.NUM_DIGITS(ND)) bus ();

    display_scanner #(
        .NUM_DIGITS(ND), .CLK_DIV(CD), .BLANK_CYCLES(BC), .ANODE_ACTIVE_LOW(1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    logic [15:0] h_dig [HMAX];
    logic [3:0]  h_en  [HMAX];
    logic [3:0]  h_dp  [HMAX];
    logic [3:0]  h_br  [HMAX];

    task automatic check_reset_vals(input string tag);
        chk({tag, "_anode"}, 32'(bus.anode_sel), 32'hF);
        chk({tag, "_seg"},   32'(bus.seg),       32'h7F);
        chk({tag, "_dp"},    32'(bus.dp),        32'h1);
        chk({tag, "_fd"},    32'(bus.frame_done), 32'h0);
        chk({tag, "_idx"},   32'(bus.digit_idx), 32'h0);
    endtask

    // Outputs seen in cycle k show the scanner's position in cycle k-1.
    task automatic check_outputs(input int k);
        logic [3:0]  e_an  = 4'hF;
        logic [6:0]  e_seg = 7'h7F;
        logic        e_dp  = 1'b1;
        logic        e_fd  = 1'b0;
        int          e_idx = 0;
        if (k > 0) begin
            int m    = k - 1;
            int slot = m % CD;
            int idx  = (m / CD) % ND;
            int src  = (m < FRAME) ? 0 : (m / FRAME) * FRAME - 1;
            logic [15:0] d = h_dig[src];
            logic [3:0]  en = h_en[src];
            logic [3:0]  dpv = h_dp[src];
            bit lit = (m > 0) && (slot >= BC) && en[idx];
`ifdef DISPLAY_SCANNER_PWM_EN
            lit = lit && ((slot - BC) < (((CD - BC) * int'(h_br[src])) >> 4));
`endif
            e_idx = idx;
            e_fd  = (m >= FRAME) && (m % FRAME == 0);
            if (lit) begin
                e_an  = ~(4'b0001 << idx);
                e_seg = glyph(d[4*idx +: 4]);
                e_dp  = ~dpv[idx];
            end
        end
        chk("anode_sel",  32'(bus.anode_sel),  32'(e_an));
        chk("seg",        32'(bus.seg),        32'(e_seg));
        chk("dp",         32'(bus.dp),         32'(e_dp));
        chk("digit_idx",  32'(bus.digit_idx),  32'(e_idx));
        chk("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic drive(input logic [15:0] d, input logic [3:0] en, input logic [3:0] dpv,
                         input logic [3:0] br);
        bus.digits   = d;
        bus.digit_en = en;
        bus.dp_en    = dpv;
`ifdef DISPLAY_SCANNER_PWM_EN
        bus.brightness = br;
`endif
        h_br[0] = h_br[0]; // keep array referenced in every build
    endtask

    // Called at the negedge that starts cycle 0 after reset release.
    task automatic run(input int ncyc, input bit directed);
        logic [15:0] d  = 16'h4321;
        logic [3:0]  en = 4'hF, dpv = 4'h0, br = 4'h8;
        for (int c = 0; c < ncyc; c++) begin
            if (directed) begin
                if (c == 80)  d = 16'hABCD;               // mid-frame change
                if (c == 160) begin en = 4'b0101; dpv = 4'b0010; br = 4'h0; end
                if (c == 192) begin en = 4'hF; br = 4'hF; end
                if (c >= 224 && c % 4 == 0) begin
                    d   = 16'($urandom);
                    en  = 4'($urandom);
                    dpv = 4'($urandom);
                    br  = 4'($urandom);
                end
                if (c >= ncyc - 40) begin en = 4'hF; br = 4'hF; end
            end else if (c % 7 == 0) begin
                d   = 16'($urandom);
                en  = 4'($urandom);
                dpv = 4'($urandom);
                br  = 4'($urandom);
            end
            drive(d, en, dpv, br);
            h_dig[c] = d;
            h_en[c]  = en;
            h_dp[c]  = dpv;
            h_br[c]  = br;
            check_outputs(c);
            @(negedge clk);
        end
    endtask

    initial begin
        bit seen;
        drive(16'h4321, 4'hF, 4'h0, 4'h8);
        // Reset held while the clock runs.
        repeat (3) begin
            @(negedge clk);
            check_reset_vals("rst_hold");
        end
        rst = 1'b0;
        run(320, 1'b1);

        // Wait for a lit digit, then assert reset between clock edges.
        seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (bus.anode_sel != 4'hF) seen = 1'b1;
            else @(negedge clk);
        end
        chk("drive_seen", 32'(seen), 32'h1);
        #2 rst = 1'b1;
        #1 check_reset_vals("rst_async");
        @(negedge clk);
        rst = 1'b0;
        run(200, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
